// File: rtl/sif_pkg.sv
// Shared types and helpers for the sif fixed-point datapath blocks.
// sif_sat clips a sign-extended sum to a signed width and returns {sat, value}.
package sif_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } sif_acc_state_t;

    localparam int SIF_MAX_W = 64;

    function automatic logic [SIF_MAX_W:0] sif_sat(
        input logic signed [SIF_MAX_W-1:0] sum,
        input int                          width
    );
        logic signed [SIF_MAX_W-1:0] one;
        logic signed [SIF_MAX_W-1:0] hi;
        logic signed [SIF_MAX_W-1:0] lo;
        one = {{(SIF_MAX_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (width - 1)) - one;
        // The most negative value is the bitwise complement of the most positive one.
        lo  = ~hi;
        if (sum > hi) begin
            return {1'b1, hi};
        end else if (sum < lo) begin
            return {1'b1, lo};
        end else begin
            return {1'b0, sum};
        end
    endfunction

endpackage

// File: rtl/sif_acc_fifo.sv
// Two-entry valid/ready FIFO holding {sat, result} for sif_acc.
// A push while full is taken only when the head is popped in the same cycle.
module sif_acc_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sif_acc.sv
// Streaming dot-product accumulator behind sif_mult: sums cfg_len products, narrows, queues.
// Define SIF_ACC_SAT_EN to clip results to WIDTH bits; otherwise results wrap.
module sif_acc
    import sif_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 P_vld,
    input  logic [WIDTH-1:0]     P_dat,
    output logic                 P_rdy,
    output logic                 S_vld,
    output logic [WIDTH-1:0]     S_dat,
    output logic                 S_sat,
    input  logic                 S_rdy,
    output logic                 drop_err
);

    sif_acc_state_t       state;
    sif_acc_state_t       state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] p_ext;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] cnt_nxt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_eff;
    logic [LEN_WIDTH-1:0] len_cur;
    logic                 last;
    logic                 beat;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WIDTH:0]       fifo_dout;
    logic [WIDTH-1:0]     res_dat;
    logic                 res_sat;

    assign p_ext   = {{(ACC_WIDTH-WIDTH){P_dat[WIDTH-1]}}, P_dat};
    assign len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    // In IDLE the group has not latched its length yet, so use the live config.
    assign len_cur = (state == IDLE) ? len_eff : len_q;
    assign cnt_nxt = cnt + LEN_WIDTH'(1);
    assign last    = (cnt_nxt == len_cur);
    assign sum     = acc + p_ext;

`ifdef SIF_ACC_SAT_EN
    logic [SIF_MAX_W:0]         sat_res;
    logic [SIF_MAX_W-WIDTH-1:0] unused_sat_hi;
    assign sat_res       = sif_sat({{(SIF_MAX_W-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum}, WIDTH);
    assign res_dat       = sat_res[WIDTH-1:0];
    assign res_sat       = sat_res[SIF_MAX_W];
    assign unused_sat_hi = sat_res[SIF_MAX_W-1:WIDTH];
`else
    assign res_dat = sum[WIDTH-1:0];
    assign res_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (beat) begin
            state_nxt = last ? IDLE : ACC;
        end
    end

    // Only a completing beat needs FIFO room; everything else is always absorbed.
    always_comb begin
        P_rdy     = !(fifo_full && !fifo_pop && last);
        beat      = P_vld && P_rdy;
        fifo_push = beat && last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            len_q    <= LEN_WIDTH'(1);
            drop_err <= 1'b0;
        end else begin
            if (beat) begin
                if (state == IDLE) begin
                    len_q <= len_eff;
                end
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt_nxt;
                end
            end
            if (P_vld && !P_rdy) begin
                drop_err <= 1'b1;
            end
        end
    end

    assign fifo_pop = S_vld && S_rdy;

    sif_acc_fifo #(
        .W(WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({res_sat, res_dat}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign S_vld = !fifo_empty;
    assign S_dat = fifo_empty ? '0 : fifo_dout[WIDTH-1:0];
    assign S_sat = fifo_empty ? 1'b0 : fifo_dout[WIDTH];

endmodule

// File: tb/tb_sif_acc.sv
// Scoreboard bench for sif_acc: directed groups plus random traffic against a behavioural model.
// Honours SIF_ACC_SAT_EN the same way as the design.
module tb_sif_acc;

    localparam int WIDTH     = 16;
    localparam int ACC_WIDTH = 40;
    localparam int LEN_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [LEN_WIDTH-1:0] cfg_len = '0;
    logic                 P_vld = 1'b0;
    logic [WIDTH-1:0]     P_dat = '0;
    logic                 P_rdy;
    logic                 S_vld;
    logic [WIDTH-1:0]     S_dat;
    logic                 S_sat;
    logic                 S_rdy = 1'b0;
    logic                 drop_err;

    sif_acc #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_len  (cfg_len),
        .P_vld    (P_vld),
        .P_dat    (P_dat),
        .P_rdy    (P_rdy),
        .S_vld    (S_vld),
        .S_dat    (S_dat),
        .S_sat    (S_sat),
        .S_rdy    (S_rdy),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] exp_q[$];

    // Reference model: products of the open group, results awaiting transfer, sticky drop.
    int     grp_cnt = 0;
    int     grp_len = 1;
    longint grp_sum = 0;
    int     occ     = 0;
    logic   drop_m  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_narrow(input longint s);
        longint      hi;
        longint      lo;
        logic [63:0] u;
        hi = (longint'(1) << (WIDTH - 1)) - 1;
        lo = -hi - 1;
        u  = s;
`ifdef SIF_ACC_SAT_EN
        if (s > hi) begin
            u = hi;
            return {1'b1, u[WIDTH-1:0]};
        end
        if (s < lo) begin
            u = lo;
            return {1'b1, u[WIDTH-1:0]};
        end
        return {1'b0, u[WIDTH-1:0]};
`else
        return {1'b0, u[WIDTH-1:0]};
`endif
    endfunction

    task automatic step(input logic r, input logic v, input int d, input int len, input logic sr);
        logic               prdy_exp;
        logic               last_m;
        logic               pop_m;
        int                 eff;
        logic signed [15:0] sd;
        @(negedge clk);
        rst     = r;
        P_vld   = v;
        P_dat   = d[WIDTH-1:0];
        cfg_len = len[LEN_WIDTH-1:0];
        S_rdy   = sr;
        #1;
        eff      = (grp_cnt == 0) ? ((len == 0) ? 1 : len) : grp_len;
        last_m   = (grp_cnt + 1 == eff);
        pop_m    = (occ > 0) && sr;
        prdy_exp = !(occ == 2 && !pop_m && last_m);
        if (!r) begin
            check("p_rdy", P_rdy, prdy_exp);
            check("s_vld", S_vld, occ > 0);
            check("drop_err", drop_err, drop_m);
        end
        @(posedge clk);
        if (r) begin
            grp_cnt = 0;
            grp_sum = 0;
            occ     = 0;
            drop_m  = 1'b0;
            exp_q.delete();
        end else begin
            if (v) begin
                if (prdy_exp) begin
                    if (grp_cnt == 0) begin
                        grp_len = eff;
                        grp_sum = 0;
                    end
                    sd      = d[15:0];
                    grp_sum = grp_sum + sd;
                    grp_cnt++;
                    if (grp_cnt == grp_len) begin
                        exp_q.push_back(ref_narrow(grp_sum));
                        occ++;
                        grp_cnt = 0;
                    end
                end else begin
                    drop_m = 1'b1;
                end
            end
            if (pop_m) occ--;
        end
    endtask

    // Monitor: every transfer must match the oldest expected result.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && S_vld && S_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got %0d, expected no result (t=%0t)", S_dat, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("s_dat", S_dat, e[15:0]);
                    check("s_sat", S_sat, e[16]);
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("rst_s_vld", S_vld, 0);
        check("rst_s_dat", S_dat, 0);
        check("rst_s_sat", S_sat, 0);
        check("rst_drop_err", drop_err, 0);
        check("rst_p_rdy", P_rdy, 1);

        // basic group
        for (int i = 1; i <= 4; i++) step(0, 1, i, 4, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4, 1);

        // degenerate lengths
        step(0, 1, -5, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, -5, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);

        // saturation / wrap
        for (int i = 0; i < 3; i++) step(0, 1, 30000, 3, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 3, 1);
        for (int i = 0; i < 3; i++) step(0, 1, -30000, 3, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 3, 1);

        // back-pressure and drop
        step(0, 1, 7, 1, 0);
        step(0, 1, 8, 1, 0);
        step(0, 1, 9, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

        // mid-group reset
        step(0, 1, 100, 4, 1);
        step(0, 1, 100, 4, 1);
        step(1, 0, 0, 4, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 4, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4, 1);

        // back-to-back groups
        for (int i = 1; i <= 6; i++) step(0, 1, i, 2, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 2, 1);

        // random traffic with random back-pressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 4)),
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        end

        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sif_acc.md
# sif_acc

Streaming fixed-point accumulator that sits directly downstream of the `sif_mult` fixed-point multiplier. It consumes the product stream (`P_vld`/`P_dat`) and sums `cfg_len` consecutive products into one dot-product result. It then saturates (or truncates) the sum back to `WIDTH` bits and delivers it through a 2-entry output FIFO with a valid/ready handshake. The multiplier does not honour back-pressure, so dropped beats are detected and flagged rather than stalled.

## Interface
- `WIDTH`, default 16: product and result width; signed two's complement, same Q-format as the multiplier output.
- `ACC_WIDTH`, default 40: internal accumulator width; must be ≥ `WIDTH` + `LEN_WIDTH`.
- `LEN_WIDTH`, default 16: width of `cfg_len`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_len` in `LEN_WIDTH`: number of products per result; sampled on the first beat of each group; 0 is treated as 1.
- `P_vld` in 1: product valid, from the multiplier.
- `P_dat` in `WIDTH`: signed product.
- `P_rdy` out 1: beat can be absorbed this cycle.
- `S_vld` out 1: result valid.
- `S_dat` out `WIDTH`: result.
- `S_sat` out 1: result was clipped (qualified by `S_vld`).
- `S_rdy` in 1: downstream accepts the result.
- `drop_err` out 1: sticky flag, set when `P_vld && !P_rdy`; cleared only by `rst`.

## Operation
- States:
  - `IDLE` (cnt = 0, acc = 0).
  - `ACC` (group in progress).
- Beat accepted = `P_vld && P_rdy`.
- In `IDLE`, an accepted beat does the following:
  - latches `len_q = max(cfg_len,1)`;
  - sets acc = sext(`P_dat`) and cnt = 1;
  - goes to `ACC`. If `len_q == 1`, it completes immediately (see below).
- In `ACC`, an accepted beat sets acc = acc + sext(`P_dat`) and cnt = cnt + 1. The add wraps modulo 2^`ACC_WIDTH` and has no internal overflow detection.
- Completion, when the accepted beat makes cnt == `len_q`:
  - sum = acc + sext(`P_dat`), i.e. it includes the final beat;
  - the sum is narrowed (see Configuration) and pushed into the FIFO together with its sat bit;
  - acc and cnt clear and the state returns to `IDLE` in the same cycle.
- Back-to-back groups are allowed with no bubble: a beat in the cycle after completion starts the next group.
- `P_rdy` = !(fifo_full && !fifo_pop && beat would complete). Non-final beats are always accepted.
- A beat with `P_vld && !P_rdy` is discarded and sets `drop_err`. Counter and accumulator are unchanged.
- `cfg_len` changes mid-group have no effect until the next `IDLE`.

## Timing
- Reset values:
  - `S_vld`=0, `S_dat`=0, `S_sat`=0, `drop_err`=0, `P_rdy`=1;
  - state `IDLE`, FIFO empty.
- Latency: final beat accepted at cycle t → `S_vld`=1 at t+1 (FIFO was empty).
- Output handshake: a transfer occurs when `S_vld && S_rdy`. While `S_vld` is high, `S_dat` and `S_sat` are held stable until the transfer.
- FIFO depth is 2. Simultaneous push and pop when full is legal; occupancy stays at 2.
- Simultaneous push and pop when empty: the pushed entry appears at t+1. There is no combinational bypass.
- Reset mid-group discards the partial sum and all FIFO contents.

## Configuration
- Macro `SIF_ACC_SAT_EN`:
  - **Defined:** the sum is clipped to [−2^(`WIDTH`−1), 2^(`WIDTH`−1)−1]. `S_sat`=1 when clipping occurred.
  - **Not defined:** `S_dat` = sum[`WIDTH`−1:0] (wrap) and `S_sat` is tied to 0.

## Structure
- Shared package `sif_pkg` holds:
  - the state enum `sif_acc_state_t` (`IDLE`, `ACC`);
  - the function `sif_sat(sum, width)` → {sat, value}.
- One sub-module, `sif_acc_fifo`: a 2-entry valid/ready FIFO, `WIDTH`+1 bits wide, with `full`, `empty`, `push`, `pop`.
- Top level holds the counter, accumulator, narrowing logic and `drop_err`.

## Test plan
- **Basic group:** `cfg_len`=4, products 1, 2, 3, 4 on consecutive cycles with `S_rdy`=1 → `S_vld` one cycle after the 4th beat, `S_dat`=10, `S_sat`=0.
- **Degenerate lengths:** `cfg_len`=0, then 1, each with a single beat of −5 → two results of −5, each one cycle after its beat.
- **Saturation** (with `SIF_ACC_SAT_EN`, `WIDTH`=16): `cfg_len`=3, beats 30000 ×3 → `S_dat`=32767, `S_sat`=1. Without the macro → `S_dat`=90000 mod 65536 reinterpreted as signed = 24464, `S_sat`=0.
- **Back-pressure and drop:** `cfg_len`=1, `S_rdy`=0, beats 7, 8, 9 → FIFO holds 7 and 8. The third beat sees `P_rdy`=0 and is dropped; `drop_err`=1. Raising `S_rdy` yields 7 then 8 only.
- **Mid-group reset:** `cfg_len`=4, two beats of 100, then `rst` for 1 cycle, then beats 1, 1, 1, 1 → single result 4, no residue of 200.
- **Back-to-back groups:** `cfg_len`=2, continuous beats 1..6 → results 3, 7, 11 on consecutive cycles with `S_rdy`=1.
